sm_bank_scheduler: RTL
======================

SM_BANK_SCHEDULER -- requirements
Module: sm_bank_scheduler

Interface
REQ-001 SHALL have parameter DW, default 64, survivor word width (one select bit per trellis state).
REQ-002 SHALL have parameter DEPTH, default 21, words per bank; AW = 5 is the bank address width.
REQ-003 SHALL have port clk  in  1  the single clock; all state on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port flush  in  1  synchronous return to the reset state.
REQ-006 SHALL have port sel_valid  in  1  a survivor word is present this cycle.
REQ-007 SHALL have port sel_in  in  DW  survivor word from the PMU.
REQ-008 SHALL have port cs  out  6  per-bank chip select.
REQ-009 SHALL have port we  out  6  per-bank write enable.
REQ-010 SHALL have port addr  out  30  per-bank address; bank b at bits [5b+4:5b].
REQ-011 SHALL have port wdata  out  DW  shared write data for all banks.
REQ-012 SHALL have port wr_bank  out  3  index of the current write bank (0..5).
REQ-013 SHALL have port dec_bank  out  3  index of the current decode bank (0..5).
REQ-014 SHALL have port role_valid  out  5  bit k-1 set when role k (1..5) holds written data.
REQ-015 SHALL have port phase  out  5  in-epoch index (0..DEPTH-1) of the issued operation.
REQ-016 SHALL have port epoch_start  out  1  one-cycle pulse with the first operation of each epoch.

Function
REQ-017 SHALL keep internal counters: ph (0..DEPTH-1), W (0..5) and fill (0..5, saturating).
REQ-018 SHALL leave all counters unchanged and drive cs = 0 and we = 0 in any cycle after sel_valid was 0.
REQ-019 SHALL advance on each accepted word (sel_valid = 1): ph increments; at ph = DEPTH-1, ph wraps to 0, W wraps 5 to 0, and fill increments, saturating at 5.
REQ-020 SHALL assign each bank b the role r = (W - b) mod 6:
  - r = 0: write
  - r = 1..4: traceback reads
  - r = 5: decode read
REQ-021 SHALL register outputs: a word accepted in cycle n produces cs/we/addr/wdata/phase in cycle n+1 (latency 1).
REQ-022 SHALL, for the write bank, drive cs = 1, we = 1, addr = ph and wdata = sel_in.
REQ-023 SHALL, for each read bank of role r, drive we = 0, addr = DEPTH-1-ph and cs = role_valid[r-1]; banks holding unwritten data are never selected.
REQ-024 SHALL compute role_valid[k-1] = (fill >= k), using the fill value in force at issue time.
REQ-025 SHALL pulse epoch_start with every issued operation at ph = 0, including the first after reset or flush.
REQ-026 SHALL drive addr and wdata to 0 for banks not selected.
REQ-027 SHALL give flush priority over sel_valid in the same cycle: counters clear and no operation issues next cycle.
REQ-028 SHALL continue the rotation seamlessly when sel_valid is held high across an epoch boundary, with no bubble.

Reset
REQ-029 SHALL, on reset assertion (any time, including mid-epoch), immediately force these values, held until the first accepted word:
  - cs = 0, we = 0, addr = 0, wdata = 0
  - wr_bank = 0, dec_bank = 1, role_valid = 0
  - phase = 0, epoch_start = 0
  - ph = 0, W = 0, fill = 0

Structure
REQ-030 SHALL take NBANK = 6, DEPTH, AW and the role encodings (ROLE_WR, ROLE_TB1..4, ROLE_DEC) from the shared package viterbi_pkg.
REQ-031 SHALL contain one sub-module, bank_rotator: the ph/W/fill counter set with wrap and saturation; all role decoding and output registers stay in sm_bank_scheduler.

Verification
REQ-032 SHALL test reset: assert reset mid-epoch at ph = 7, W = 3 -> all outputs at reset values immediately; the first word after release writes bank 0 at addr 0 with epoch_start = 1.
REQ-033 SHALL test fill: 21 continuous words 0x1..0x15 -> bank 0 written at addr 0..20 with those values, no read cs, wr_bank = 1 from word 22.
REQ-034 SHALL test steady state: 126 continuous words -> in epoch 6, cs = 6'b111111 every cycle, exactly one we bit set, reads at addr 20 down to 0, dec_bank = (wr_bank + 1) mod 6.
REQ-035 SHALL test stalls: sel_valid toggling 1,0,0,1 -> no cs on the stall cycles; the second write uses addr = previous + 1.
REQ-036 SHALL test wrap: W = 5, ph = 20, then one more word -> W = 0, ph = 0, epoch_start = 1, fill saturated at 5.
REQ-037 SHALL test flush: flush and sel_valid both high at ph = 10 -> no issue next cycle, state returns to reset values.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared constants and helpers for the Viterbi survivor-memory bank scheduler.
// Contents:
//   NBANK, DEPTH, AW  - bank count, words per bank, bank address width
//   role_e            - role a bank plays within the current rotation
//   role_of()         - role of bank b when the write pointer is w
//   next_bank()       - modulo-NBANK increment of a bank index
package viterbi_pkg;

  localparam int NBANK = 6;
  localparam int DEPTH = 21;
  localparam int AW    = 5;

  typedef enum logic [2:0] {
    ROLE_WR  = 3'd0,
    ROLE_TB1 = 3'd1,
    ROLE_TB2 = 3'd2,
    ROLE_TB3 = 3'd3,
    ROLE_TB4 = 3'd4,
    ROLE_DEC = 3'd5
  } role_e;

  // (w - b) mod 6. The +6 keeps the subtraction non-negative in 4 bits.
  function automatic role_e role_of(input logic [2:0] w, input logic [2:0] b);
    logic [3:0] d;
    d = 4'(w) + 4'd6 - 4'(b);
    if (d >= 4'd6) d = d - 4'd6;
    return role_e'(d[2:0]);
  endfunction

  function automatic logic [2:0] next_bank(input logic [2:0] b);
    return (b == 3'(NBANK - 1)) ? 3'd0 : b + 3'd1;
  endfunction

endpackage

// File: rtl/bank_rotator.sv
// Counter set that drives the bank rotation.
// Ports:
//   clk, reset (async, active-high), flush (sync clear)
//   adv   - one survivor word accepted this cycle
//   ph    - in-epoch word index, 0..DEPTH-1
//   w     - current write bank, 0..NBANK-1
//   fill  - completed epochs, saturating at NBANK-1
// All outputs are the values in force for the word being accepted now;
// the advanced values appear on the next clock.
module bank_rotator
  import viterbi_pkg::*;
#(
  parameter int DEPTH = viterbi_pkg::DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          adv,
  output logic [AW-1:0] ph,
  output logic [2:0]    w,
  output logic [2:0]    fill
);

  localparam logic [AW-1:0] PH_LAST   = AW'(DEPTH - 1);
  localparam logic [2:0]    FILL_MAX  = 3'(NBANK - 1);

  logic [AW-1:0] ph_q, ph_d;
  logic [2:0]    w_q, w_d;
  logic [2:0]    fill_q, fill_d;

  always_comb begin
    ph_d   = ph_q;
    w_d    = w_q;
    fill_d = fill_q;
    if (flush) begin
      ph_d   = '0;
      w_d    = '0;
      fill_d = '0;
    end else if (adv) begin
      if (ph_q == PH_LAST) begin
        // Epoch boundary: the rotation moves to the next bank and one more
        // bank now holds a complete epoch of survivors.
        ph_d   = '0;
        w_d    = next_bank(w_q);
        fill_d = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 3'd1;
      end else begin
        ph_d = ph_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph_q   <= '0;
      w_q    <= '0;
      fill_q <= '0;
    end else begin
      ph_q   <= ph_d;
      w_q    <= w_d;
      fill_q <= fill_d;
    end
  end

  assign ph   = ph_q;
  assign w    = w_q;
  assign fill = fill_q;

endmodule

// File: rtl/sm_bank_scheduler.sv
// Survivor-memory bank scheduler for a Viterbi decoder.
// Six single-port banks rotate through the roles write / traceback 1..4 /
// decode. Each accepted survivor word issues, one cycle later, a write to the
// write bank and a read of every other bank that already holds data.
// Ports:
//   clk, reset (async, active-high), flush (sync return to reset state)
//   sel_valid, sel_in     - survivor word input
//   cs, we, addr          - per-bank strobes; bank b address at addr[5b+4:5b]
//   wdata                 - shared write data (0 when nothing is written)
//   wr_bank, dec_bank     - write and decode bank of the issued operation
//   role_valid            - bit k-1 set when role k holds written data
//   phase, epoch_start    - in-epoch index of the issued op, pulse at index 0
// Handshake: sel_valid has no back-pressure; a word is accepted in every
// cycle where sel_valid is high and flush is low, and its operation appears
// on the outputs exactly one cycle later. wr_bank/dec_bank/role_valid/phase
// describe the most recently issued operation and hold across idle cycles.
module sm_bank_scheduler
  import viterbi_pkg::*;
#(
  parameter int DW    = 64,
  parameter int DEPTH = viterbi_pkg::DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                sel_valid,
  input  logic [DW-1:0]       sel_in,
  output logic [NBANK-1:0]    cs,
  output logic [NBANK-1:0]    we,
  output logic [NBANK*AW-1:0] addr,
  output logic [DW-1:0]       wdata,
  output logic [2:0]          wr_bank,
  output logic [2:0]          dec_bank,
  output logic [NBANK-2:0]    role_valid,
  output logic [AW-1:0]       phase,
  output logic                epoch_start
);

  localparam logic [AW-1:0] PH_LAST = AW'(DEPTH - 1);

  logic [AW-1:0] ph;
  logic [2:0]    w;
  logic [2:0]    fill;

  bank_rotator #(.DEPTH(DEPTH)) u_rotator (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .adv   (sel_valid),
    .ph    (ph),
    .w     (w),
    .fill  (fill)
  );

  logic [NBANK-1:0]    cs_q, cs_d;
  logic [NBANK-1:0]    we_q, we_d;
  logic [NBANK*AW-1:0] addr_q, addr_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [2:0]          wr_bank_q, wr_bank_d;
  logic [2:0]          dec_bank_q, dec_bank_d;
  logic [NBANK-2:0]    role_valid_q, role_valid_d;
  logic [AW-1:0]       phase_q, phase_d;
  logic                epoch_start_q, epoch_start_d;

  logic [NBANK-2:0]    rv_now;
  logic [2:0]          r;

  always_comb begin
    cs_d          = '0;
    we_d          = '0;
    addr_d        = '0;
    wdata_d       = '0;
    epoch_start_d = 1'b0;
    wr_bank_d     = wr_bank_q;
    dec_bank_d    = dec_bank_q;
    role_valid_d  = role_valid_q;
    phase_d       = phase_q;
    r             = '0;

    // Role k holds written data once k epochs have completed.
    for (int k = 1; k < NBANK; k++) begin
      rv_now[k-1] = (fill >= 3'(k));
    end

    if (flush) begin
      wr_bank_d    = '0;
      dec_bank_d   = 3'd1;
      role_valid_d = '0;
      phase_d      = '0;
    end else if (sel_valid) begin
      for (int b = 0; b < NBANK; b++) begin
        r = role_of(w, 3'(b));
        if (r == ROLE_WR) begin
          cs_d[b]            = 1'b1;
          we_d[b]            = 1'b1;
          addr_d[AW*b +: AW] = ph;
        end else if (rv_now[r - 3'd1]) begin
          // Reads walk the bank backwards so traceback starts at the newest word.
          cs_d[b]            = 1'b1;
          addr_d[AW*b +: AW] = PH_LAST - ph;
        end
      end
      wdata_d       = sel_in;
      wr_bank_d     = w;
      dec_bank_d    = next_bank(w);
      role_valid_d  = rv_now;
      phase_d       = ph;
      epoch_start_d = (ph == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_q          <= '0;
      we_q          <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wr_bank_q     <= '0;
      dec_bank_q    <= 3'd1;
      role_valid_q  <= '0;
      phase_q       <= '0;
      epoch_start_q <= 1'b0;
    end else begin
      cs_q          <= cs_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wr_bank_q     <= wr_bank_d;
      dec_bank_q    <= dec_bank_d;
      role_valid_q  <= role_valid_d;
      phase_q       <= phase_d;
      epoch_start_q <= epoch_start_d;
    end
  end

  assign cs          = cs_q;
  assign we          = we_q;
  assign addr        = addr_q;
  assign wdata       = wdata_q;
  assign wr_bank     = wr_bank_q;
  assign dec_bank    = dec_bank_q;
  assign role_valid  = role_valid_q;
  assign phase       = phase_q;
  assign epoch_start = epoch_start_q;

endmodule
